// File: rtl/down_timer_8.sv
// Loadable down-counting timer with pause/resume, one-shot or auto-reload
// mode and a clock prescaler. Emits a one-cycle tc pulse on each terminal count.
module down_timer_8 #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic [1:0]       dbg_state
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      tc_q     <= tc_d;
    end
  end

  // Priority per edge is load > stop > start; tc defaults low so it only
  // survives the single cycle after a terminal tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      pre_d    = '0;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (!stop && start && (count_q != '0)) begin
            state_d = S_RUN;
            pre_d   = '0;
          end
        end
        S_HOLD: begin
          if (!stop && start) state_d = S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_HOLD;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = S_DONE;
              end
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign count     = count_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign tc        = tc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_down_timer_8.sv
// Directed bench for down_timer_8: one instance with PRESCALE=1 and one with
// PRESCALE=4, sharing clock and reset.
module tb_down_timer_8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0, auto_reload = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] count;
  logic       busy, done, tc;
  logic [1:0] state;

  logic       p_load = 1'b0, p_start = 1'b0, p_stop = 1'b0, p_auto = 1'b0;
  logic [7:0] p_load_val = '0;
  logic [7:0] p_count;
  logic       p_busy, p_done, p_tc;
  logic [1:0] p_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  down_timer_8 #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done), .tc(tc), .dbg_state(state)
  );

  down_timer_8 #(.WIDTH(8), .PRESCALE(4)) dut_p4 (
    .clk(clk), .reset(reset), .load(p_load), .load_val(p_load_val),
    .start(p_start), .stop(p_stop), .auto_reload(p_auto),
    .count(p_count), .busy(p_busy), .done(p_done), .tc(p_tc), .dbg_state(p_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_tests++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d busy=%b done=%b tc=%b st=%0d, want 0/0/0/0/IDLE",
               count, busy, done, tc, state);
    end
    tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if (p_count !== 8'd0 || p_busy !== 1'b0 || p_done !== 1'b0 || p_tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_p4: count=%0d busy=%b done=%b tc=%b, want 0/0/0/0",
               p_count, p_busy, p_done, p_tc);
    end
  endtask

  task automatic test_one_shot();
    do_load(8'd5);
    n_tests++;
    if (count !== 8'd5 || busy !== 1'b0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL oneshot_load: count=%0d busy=%b st=%0d, want 5/0/IDLE", count, busy, state);
    end
    do_start();
    n_tests++;
    if (count !== 8'd5 || busy !== 1'b1 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_start: count=%0d busy=%b tc=%b, want 5/1/0", count, busy, tc);
    end
    for (int i = 4; i >= 0; i--) begin
      tick();
      n_tests++;
      if (count !== 8'(i) || tc !== (i == 0)) begin
        n_fail++;
        $display("FAIL oneshot_count[%0d]: count=%0d tc=%b, want %0d/%b", i, count, tc, i, (i == 0));
      end
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || state !== ST_DONE) begin
      n_fail++;
      $display("FAIL oneshot_done: done=%b busy=%b st=%0d, want 1/0/DONE", done, busy, state);
    end
    tick();
    n_tests++;
    if (tc !== 1'b0 || count !== 8'd0) begin
      n_fail++;
      $display("FAIL oneshot_tc_width: tc=%b count=%0d, want 0/0", tc, count);
    end
    do_start();
    tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 8'd0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_restart_zero: done=%b busy=%b count=%0d tc=%b, want 1/0/0/0",
               done, busy, count, tc);
    end
  endtask

  task automatic test_auto_reload();
    int exp_seq[8];
    exp_seq = '{2, 1, 3, 2, 1, 3, 2, 1};
    auto_reload = 1'b1;
    do_load(8'd3);
    do_start();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (count !== 8'(exp_seq[i]) || tc !== (exp_seq[i] == 3) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL autoreload[%0d]: count=%0d tc=%b busy=%b done=%b, want %0d/%b/1/0",
                 i, count, tc, busy, done, exp_seq[i], (exp_seq[i] == 3));
      end
    end
    // auto_reload dropped before the next count==1 tick turns it into a one-shot
    auto_reload = 1'b0;
    tick();
    n_tests++;
    if (count !== 8'd0 || tc !== 1'b1 || state !== ST_DONE) begin
      n_fail++;
      $display("FAIL autoreload_off: count=%0d tc=%b st=%0d, want 0/1/DONE", count, tc, state);
    end
  endtask

  task automatic test_pause_resume();
    do_load(8'd10);
    do_start();
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (count !== 8'd7) begin
      n_fail++;
      $display("FAIL pause_pre: count=%0d, want 7", count);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (count !== 8'd7 || busy !== 1'b0 || state !== ST_HOLD) begin
        n_fail++;
        $display("FAIL pause_hold[%0d]: count=%0d busy=%b st=%0d, want 7/0/HOLD", i, count, busy, state);
      end
      tick();
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    n_tests++;
    if (state !== ST_HOLD || count !== 8'd7) begin
      n_fail++;
      $display("FAIL pause_start_stop: st=%0d count=%0d, want HOLD/7", state, count);
    end
    do_start();
    n_tests++;
    if (busy !== 1'b1 || count !== 8'd7) begin
      n_fail++;
      $display("FAIL pause_resume: busy=%b count=%0d, want 1/7", busy, count);
    end
    for (int i = 6; i >= 0; i--) begin
      tick();
      n_tests++;
      if (count !== 8'(i) || tc !== (i == 0)) begin
        n_fail++;
        $display("FAIL pause_count[%0d]: count=%0d tc=%b, want %0d/%b", i, count, tc, i, (i == 0));
      end
    end
  endtask

  task automatic test_load_mid_run();
    do_load(8'd8);
    do_start();
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (count !== 8'd5) begin
      n_fail++;
      $display("FAIL midload_pre: count=%0d, want 5", count);
    end
    do_load(8'd2);
    tick();
    n_tests++;
    if (count !== 8'd2 || busy !== 1'b0 || state !== ST_IDLE || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_abort: count=%0d busy=%b st=%0d tc=%b, want 2/0/IDLE/0",
               count, busy, state, tc);
    end
    do_load(8'd0);
    do_start();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (state !== ST_IDLE || busy !== 1'b0 || count !== 8'd0 || tc !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_start[%0d]: st=%0d busy=%b count=%0d tc=%b, want IDLE/0/0/0",
                 i, state, busy, count, tc);
      end
      tick();
    end
  endtask

  task automatic test_prescaler();
    p_load = 1'b1; p_load_val = 8'd2;
    tick();
    p_load = 1'b0; p_start = 1'b1;
    tick();
    p_start = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      n_tests++;
      if (p_count !== ((j < 4) ? 8'd2 : (j < 8) ? 8'd1 : 8'd0) || p_tc !== (j == 8)) begin
        n_fail++;
        $display("FAIL prescale_edge[%0d]: count=%0d tc=%b", j, p_count, p_tc);
      end
    end
    // Two running edges put the prescaler at phase 2; the resume must finish
    // that phase in two edges rather than restarting a full period.
    p_load = 1'b1; p_load_val = 8'd2;
    tick();
    p_load = 1'b0; p_start = 1'b1;
    tick();
    p_start = 1'b0;
    tick();
    tick();
    p_stop = 1'b1;
    tick();
    p_stop = 1'b0;
    tick();
    tick();
    n_tests++;
    if (p_state !== ST_HOLD || p_count !== 8'd2) begin
      n_fail++;
      $display("FAIL prescale_hold: st=%0d count=%0d, want HOLD/2", p_state, p_count);
    end
    p_start = 1'b1;
    tick();
    p_start = 1'b0;
    tick();
    n_tests++;
    if (p_count !== 8'd2) begin
      n_fail++;
      $display("FAIL prescale_resume1: count=%0d, want 2", p_count);
    end
    tick();
    n_tests++;
    if (p_count !== 8'd1) begin
      n_fail++;
      $display("FAIL prescale_resume2: count=%0d, want 1", p_count);
    end
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (p_count !== 8'd0 || p_tc !== 1'b1 || p_done !== 1'b1) begin
      n_fail++;
      $display("FAIL prescale_tc: count=%0d tc=%b done=%b, want 0/1/1", p_count, p_tc, p_done);
    end
  endtask

  task automatic test_async_reset();
    do_load(8'd5);
    do_start();
    tick();
    tick();
    n_tests++;
    if (count !== 8'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: count=%0d busy=%b, want 3/1", count, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL areset_now: count=%0d busy=%b done=%b tc=%b st=%0d, want 0/0/0/0/IDLE",
               count, busy, done, tc, state);
    end
    tick();
    reset = 1'b1;
    tick();
    do_start();
    tick();
    n_tests++;
    if (busy !== 1'b0 || count !== 8'd0 || tc !== 1'b0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL areset_start_zero: busy=%b count=%0d tc=%b st=%0d, want 0/0/0/IDLE",
               busy, count, tc, state);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause_resume();
    test_load_mid_run();
    test_prescaler();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
